// File: rtl/data_mem_arb_if.sv
// rtl/data_mem_arb_if.sv - write/read request channels of the frame buffer memory
interface data_mem_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                      wr_en;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [DATA_WIDTH/8-1:0]   wr_be;
  logic                      wr_ready;
  logic                      rd_en;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic                      rd_ready;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_valid;
  logic                      init_done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  wr_ready, rd_ready, rd_data, rd_valid, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output wr_ready, rd_ready, rd_data, rd_valid, init_done
  );
endinterface

// File: rtl/data_mem_arb.sv
// rtl/data_mem_arb.sv - arbitrated single-port frame buffer memory with clear sweep
module data_mem_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int MEM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_arb_if.slave  bus
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {ST_INIT, ST_CLEAR, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic                    prio_rd_q, prio_rd_d;   // 0: write wins a tie, 1: read wins
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

  logic                    wr_req, rd_req;
  logic                    wr_ready_c, rd_ready_c, init_done_c;
  logic                    wr_acc, rd_acc;
  logic                    wr_in_rng, rd_in_rng;
  logic [DATA_WIDTH-1:0]   rd_sample;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   pipe_data_q [RD_LAT];
  logic [RD_LAT-1:0]       pipe_vld_q;

  assign wr_req    = ~bus.wr_en;
  assign rd_req    = ~bus.rd_en;
  assign wr_acc    = wr_req & wr_ready_c;
  assign rd_acc    = rd_req & rd_ready_c;
  assign wr_in_rng = {1'b0, bus.wr_addr} < DEPTH_L;
  assign rd_in_rng = {1'b0, bus.rd_addr} < DEPTH_L;
  // Out-of-range reads still complete, returning zero.
  assign rd_sample = rd_in_rng ? mem[bus.rd_addr] : '0;

  // State, tie-break priority and clear counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      prio_rd_q <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Sequencing through init/clear and ready arbitration in RUN.
  always_comb begin
    state_d     = state_q;
    prio_rd_d   = prio_rd_q;
    clr_cnt_d   = clr_cnt_q;
    wr_ready_c  = 1'b0;
    rd_ready_c  = 1'b0;
    init_done_c = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_cnt_d = '0;
        state_d   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      end
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) state_d = ST_RUN;
        else                        clr_cnt_d = clr_cnt_q + 1'b1;
      end
      ST_RUN: begin
        init_done_c = 1'b1;
        if (wr_req && rd_req) begin
          // Contended: holder wins, priority passes to the loser.
          wr_ready_c = ~prio_rd_q;
          rd_ready_c = prio_rd_q;
          prio_rd_d  = ~prio_rd_q;
        end else begin
          wr_ready_c = 1'b1;
          rd_ready_c = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Array writes: clear sweep or byte-enabled request write; no reset on contents.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_acc && wr_in_rng) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (bus.wr_be[k]) mem[bus.wr_addr][8*k +: 8] <= bus.wr_data[8*k +: 8];
      end
    end
  end

  // Read pipeline; data stages only load when a valid word moves in, so rd_data holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) pipe_data_q[k] <= '0;
    end else begin
      pipe_vld_q[0] <= rd_acc;
      if (rd_acc) pipe_data_q[0] <= rd_sample;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        if (pipe_vld_q[k-1]) pipe_data_q[k] <= pipe_data_q[k-1];
      end
    end
  end

  assign bus.wr_ready  = wr_ready_c;
  assign bus.rd_ready  = rd_ready_c;
  assign bus.init_done = init_done_c;
  assign bus.rd_data   = pipe_data_q[RD_LAT-1];
  assign bus.rd_valid  = pipe_vld_q[RD_LAT-1];

endmodule

// File: tb/tb_data_mem_arb.sv
// tb/tb_data_mem_arb.sv - directed self-checking bench for data_mem_arb
module tb_data_mem_arb;

  logic clk = 1'b0;
  logic reset;

  data_mem_arb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  data_mem_arb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_DEPTH(12), .RD_LAT(2), .CLEAR_ON_RESET(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0]  burst_addr [$];
  logic [31:0] burst_data [$];
  int          burst_first;
  int          burst_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.wr_en   = 1'b0;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_be   = be;
    tick();
    bus.wr_en   = 1'b1;
  endtask

  task automatic read_burst;
    int n;
    n = burst_addr.size();
    burst_data  = {};
    burst_first = -1;
    burst_last  = -1;
    for (int i = 0; i < n + 6; i++) begin
      if (i < n) begin
        bus.rd_en   = 1'b0;
        bus.rd_addr = burst_addr[i];
      end else begin
        bus.rd_en = 1'b1;
      end
      tick();
      if (bus.rd_valid) begin
        burst_data.push_back(bus.rd_data);
        if (burst_first < 0) burst_first = i;
        burst_last = i;
      end
    end
    bus.rd_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    int pulses;

    reset       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_addr = '0;
    bus.rd_addr = '0;
    bus.wr_data = '0;
    bus.wr_be   = '0;
    #12;
    check_eq("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
    check_eq("rst_rd_data",   bus.rd_data,        32'd0);
    check_eq("rst_init_done", 32'(bus.init_done), 32'd0);
    check_eq("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
    check_eq("rst_rd_ready",  32'(bus.rd_ready),  32'd0);

    // Clear sweep with both requests held active.
    tick();
    reset = 1'b1;
    check_eq("init_wr_ready", 32'(bus.wr_ready), 32'd0);
    check_eq("init_rd_ready", 32'(bus.rd_ready), 32'd0);
    for (int k = 0; k <= 12; k++) begin
      tick();
      check_eq($sformatf("sweep_init_done_e%0d", k), 32'(bus.init_done), (k == 12) ? 32'd1 : 32'd0);
      if (k < 12) begin
        check_eq($sformatf("sweep_wr_ready_e%0d", k), 32'(bus.wr_ready), 32'd0);
        check_eq($sformatf("sweep_rd_ready_e%0d", k), 32'(bus.rd_ready), 32'd0);
      end
    end

    // Contention: W, R, W, R with writes that change nothing.
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("cont_wr_ready_%0d", c), 32'(bus.wr_ready), (c % 2 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("cont_rd_ready_%0d", c), 32'(bus.rd_ready), (c % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    repeat (6) tick();

    // Whole array reads back zero.
    burst_addr = {};
    for (int i = 0; i < 12; i++) burst_addr.push_back(4'(i));
    read_burst();
    check_eq("clear_count", 32'(burst_data.size()), 32'd12);
    for (int i = 0; i < burst_data.size(); i++)
      check_eq($sformatf("clear_data_%0d", i), burst_data[i], 32'd0);

    // Byte enables.
    do_write(4'd3, 32'hDEADBEEF, 4'b1111);
    do_write(4'd3, 32'h00001200, 4'b0010);
    burst_addr = {4'd3};
    read_burst();
    check_eq("be_count",   32'(burst_data.size()), 32'd1);
    check_eq("be_latency", 32'(burst_first),       32'd1);
    if (burst_data.size() > 0) check_eq("be_data", burst_data[0], 32'hDEAD12EF);

    // Out of range.
    do_write(4'd13, 32'h00000055, 4'b1111);
    burst_addr = {4'd13, 4'd0};
    read_burst();
    check_eq("oor_count", 32'(burst_data.size()), 32'd2);
    for (int i = 0; i < burst_data.size(); i++)
      check_eq($sformatf("oor_data_%0d", i), burst_data[i], 32'd0);

    // Pipelined back-to-back reads.
    for (int i = 0; i < 4; i++) do_write(4'(i), 32'h10 + 32'(i), 4'b1111);
    burst_addr = {4'd0, 4'd1, 4'd2, 4'd3};
    read_burst();
    check_eq("pipe_count",  32'(burst_data.size()), 32'd4);
    check_eq("pipe_span",   32'(burst_last - burst_first), 32'd3);
    for (int i = 0; i < burst_data.size(); i++)
      check_eq($sformatf("pipe_data_%0d", i), burst_data[i], 32'h10 + 32'(i));
    check_eq("hold_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_eq("hold_rd_data",  bus.rd_data,       32'h13);

    // Zero byte enable leaves the word alone.
    do_write(4'd2, 32'hFFFFFFFF, 4'b0000);
    burst_addr = {4'd2};
    read_burst();
    check_eq("be0_count", 32'(burst_data.size()), 32'd1);
    if (burst_data.size() > 0) check_eq("be0_data", burst_data[0], 32'h12);

    // Reset during the sweep at clear address 5.
    reset = 1'b0;
    #1;
    check_eq("rst1_init_done", 32'(bus.init_done), 32'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k <= 6; k++) tick();
    reset = 1'b0;
    #1;
    check_eq("rst2_init_done", 32'(bus.init_done), 32'd0);
    tick();
    reset = 1'b1;
    done_at = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.init_done && done_at < 0) done_at = k;
    end
    check_eq("rst2_done_edge", 32'(done_at), 32'd12);
    burst_addr = {4'd1};
    read_burst();
    check_eq("rst2_cleared_count", 32'(burst_data.size()), 32'd1);
    if (burst_data.size() > 0) check_eq("rst2_cleared_data", burst_data[0], 32'd0);

    // Reset with reads in flight.
    do_write(4'd1, 32'hA5A50001, 4'b1111);
    burst_addr = {4'd1};
    read_burst();
    check_eq("pre_rst_rd_data", bus.rd_data, 32'hA5A50001);
    bus.rd_en   = 1'b0;
    bus.rd_addr = 4'd1;
    tick();
    tick();
    check_eq("inflight_rd_valid_pre", 32'(bus.rd_valid), 32'd1);
    bus.rd_en = 1'b1;
    reset = 1'b0;
    #1;
    check_eq("inflight_rd_valid_rst", 32'(bus.rd_valid), 32'd0);
    check_eq("inflight_rd_data_rst",  bus.rd_data,       32'd0);
    tick();
    reset   = 1'b1;
    pulses  = 0;
    done_at = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.rd_valid) pulses++;
      if (bus.init_done && done_at < 0) done_at = k;
    end
    check_eq("inflight_stale_pulses", 32'(pulses),  32'd0);
    check_eq("rst3_done_edge",        32'(done_at), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arb.md
# data_mem_arb

Parametrised single-port data memory for the frame buffer, with independent write and read request channels arbitrated onto one array. It adds byte-enable writes, a pipelined read path of configurable latency, fair arbitration of simultaneous requests, and an optional post-reset clear sweep. It sits between the frame writer and the display reader as their shared storage model.

## Interface

- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width in bits.
- MEM_DEPTH, 1 << ADDR_WIDTH, number of words; must be ≤ 2^ADDR_WIDTH.
- RD_LAT, 1, read latency in cycles from acceptance to rd_valid; legal range 1..4.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents undefined, no sweep.

Ports:

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request, active-low.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables, active-high; bit k covers data bits [8k+7:8k].
- wr_ready  out  1  high = a write requested this cycle is accepted at the next edge.
- rd_en  in  1  read request, active-low.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_ready  out  1  high = a read requested this cycle is accepted at the next edge.
- rd_data  out  DATA_WIDTH  read data; valid while rd_valid is high.
- rd_valid  out  1  one-cycle pulse per accepted read.
- init_done  out  1  high once the block accepts requests.

## Operation

- States: INIT, CLEAR, RUN.
  - Reset asserted: forces INIT.
  - INIT: lasts one cycle after release, then goes to CLEAR if CLEAR_ON_RESET = 1, else to RUN.
  - CLEAR: writes zero to address counter 0..MEM_DEPTH-1, one word per cycle, then goes to RUN.
  - RUN: terminal.
- init_done is high only in RUN. wr_ready and rd_ready are 0 outside RUN; requests made then are ignored, not queued.
- A request is accepted when its enable is low and its ready is high in the same cycle. Every accepted request executes, including repeats of the previous address.
- Arbitration (combinational ready, RUN only):
  - Only one channel requesting: that channel is ready.
  - Both requesting: the channel holding priority is ready and the other is not.
  - A 1-bit priority resets to write. It flips to the losing channel after each contended cycle. Uncontended cycles leave it unchanged.
- With no request, both readies are high in RUN.
- Write: at the accepting edge, each byte with wr_be[k] = 1 takes wr_data; other bytes are retained. wr_be = 0 is accepted and changes nothing.
- Read: the array is sampled at the accepting edge. The data then passes through RD_LAT-1 further register stages to rd_data.
- Address ≥ MEM_DEPTH: the request is accepted. A write is dropped; a read returns all-zero data with a normal rd_valid.
- rd_data holds its last value when rd_valid is low.
- Reset values: rd_data 0, rd_valid 0, init_done 0, wr_ready 0, rd_ready 0, priority = write, clear counter 0. The read pipeline is flushed.
- Memory contents are not reset asynchronously; they are cleared only by the sweep.

## Timing

- Reset release: let edge 0 be the first rising edge with reset high. That edge ends INIT.
  - With CLEAR_ON_RESET = 1: CLEAR occupies the next MEM_DEPTH cycles, and init_done rises at edge MEM_DEPTH.
  - With CLEAR_ON_RESET = 0: init_done rises at edge 0.
- Reset asserted mid-CLEAR or mid-RUN: outputs go to reset values immediately, with no clock required. The sweep restarts from address 0 after release.
- A read accepted at edge N: rd_valid is high and rd_data is valid for the cycle following edge N+RD_LAT-1.
- A write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Throughput: one accepted request per cycle in total. Back-to-back reads produce back-to-back rd_valid pulses in request order.

## Test plan

Configuration: DATA_WIDTH 32, ADDR_WIDTH 4, MEM_DEPTH 12, RD_LAT 2, CLEAR_ON_RESET 1.

- Clear sweep: release reset while holding wr_en and rd_en low throughout → both readies stay 0 and init_done rises at edge 12. Reading addresses 0..11 afterwards returns 0x00000000.
- Byte enables: write 0xDEADBEEF to address 3 with be 4'b1111, then 0x00001200 with be 4'b0010, then read address 3 → rd_data 0xDEAD12EF, with rd_valid 2 cycles after the read is accepted.
- Contention: hold wr_en and rd_en low for 4 cycles after init_done → grants are W, R, W, R, exactly one ready high per cycle.
- Out of range: write 0x55 to address 13, then read addresses 13 and 0 → both return 0x00000000, and exactly two rd_valid pulses occur.
- Pipelining: write 0x10..0x13 to addresses 0..3, then read 0..3 on consecutive cycles → four consecutive rd_valid cycles carrying 0x10, 0x11, 0x12, 0x13.
- Reset mid-operation:
  - Assert reset at CLEAR address 5 → init_done rises 12 cycles after the new release.
  - Assert reset with a read in flight → rd_valid is 0 immediately and no stale pulse follows release.
